id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- Registered ID/EX pipeline stage sitting directly upstream of the ALU.
- Captures decoded RV32I instruction fields and resolves operand forwarding from EX/MEM and MEM/WB.
- Selects the register, immediate or PC source for each operand.
- Rewrites iFunct3/iFunct7 so the ALU performs the correct operation: add for address calculation, sub for branch compare, clean funct7 for OP-IMM.
- Provides a valid/ready handshake with stall and flush.

Parameters:
- XLEN, 32, datapath width
- REGADDR, 5, register index width

Ports:
- iClk  in  1  clock
- iRstN  in  1  synchronous active-low reset
- iValid  in  1  decode presents an instruction
- oReady  out  1  stage can accept this cycle
- iStall  in  1  load-use hazard; hold upstream and insert a bubble
- iFlush  in  1  branch/jump taken; kill captured and incoming instruction
- iPc  in  XLEN  instruction PC
- iOpcode  in  7  instruction opcode
- iFunct3  in  3  raw funct3
- iFunct7  in  7  raw funct7
- iRs1  in  REGADDR  source register index 1
- iRs2  in  REGADDR  source register index 2
- iRd  in  REGADDR  destination register index
- iRs1Data  in  XLEN  register file read port 1
- iRs2Data  in  XLEN  register file read port 2
- iImm  in  XLEN  sign-extended immediate
- iExMemRegWrite  in  1  EX/MEM forwarding source write enable
- iExMemRd  in  REGADDR  EX/MEM forwarding source destination index
- iExMemData  in  XLEN  EX/MEM forwarding source data
- iMemWbRegWrite  in  1  MEM/WB forwarding source write enable
- iMemWbRd  in  REGADDR  MEM/WB forwarding source destination index
- iMemWbData  in  XLEN  MEM/WB forwarding source data
- iReady  in  1  EX/downstream accepts
- oValid  out  1  registered instruction valid
- oDataA  out  XLEN  ALU operand A
- oDataB  out  XLEN  ALU operand B
- oFunct3  out  3  ALU function select
- oFunct7  out  7  ALU function select
- oStoreData  out  XLEN  forwarded rs2 value for stores
- oBrFunct3  out  3  original funct3, used for branch resolution
- oRd  out  REGADDR  destination index
- oRegWrite  out  1  destination write enable
- oMemRead  out  1  load indicator
- oMemWrite  out  1  store indicator
- oPc  out  XLEN  registered PC

Behaviour:
- Reset (iRstN=0 at a rising edge): every output register is cleared to 0, including oValid. oReady is combinational and reads 0 during reset.
- oReady = iRstN & ~iStall & (~oValid | iReady).
- Accept: iValid & oReady. Captures on the next edge; latency is 1 cycle from accept to oValid.
- Drain only: oValid & iReady & ~accept. oValid is cleared to 0.
- Hold: oValid & ~iReady. All outputs stay stable; no change is allowed while stalled downstream.
- Stall: iStall=1 & (~oValid | iReady). A bubble is inserted: oValid=0, oRegWrite=0, oMemWrite=0.
- Flush: iFlush=1 clears oValid, oRegWrite, oMemRead and oMemWrite next cycle. It overrides accept, stall and hold. The data fields are don't-care.
- Forwarding, per source s in {rs1, rs2}:
  - If iExMemRegWrite & iExMemRd==s & s!=0, use iExMemData.
  - Else if iMemWbRegWrite & iMemWbRd==s & s!=0, use iMemWbData.
  - Else use the register file data.
  - EX/MEM has priority. x0 is never forwarded.
- Operand A:
  - LUI: 0.
  - AUIPC, JAL, JALR link: iPc.
  - All others: forwarded rs1.
- Operand B:
  - OP, BRANCH: forwarded rs2.
  - JAL, JALR: constant 4.
  - All others: iImm.
- ALU op rewrite:
  - OP: funct3/funct7 passed through.
  - OP-IMM: funct3 passed. funct7 = {1'b0, iFunct7[5], 5'b0} when funct3=101; 0 otherwise, so ADDI never decodes as SUB.
  - LOAD, STORE, LUI, AUIPC, JAL, JALR: funct3=000, funct7=0.
  - BRANCH: funct3=000, funct7=0100000 (subtract); oBrFunct3 = iFunct3.
- Control decode:
  - oRegWrite = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and 0 when iRd==0.
  - oMemRead = LOAD. oMemWrite = STORE.
- Unknown opcode: captured as a bubble (oValid=0).
- Reset mid-handshake: the in-flight instruction is discarded; no partial capture.

Decomposition:
- Package rv32_pkg: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR) and the funct7 SUB/SRA constants.
- One sub-module, fwd_mux: rs index, rf data and both forwarding sources in; selected XLEN data out. It is instantiated twice.

Test Plan:
- Reset then ADDI x5,x1,-1 with iRs1Data=7, iImm=FFFFFFFF, iFunct7 garbage 0100000 -> after 1 cycle: oValid=1, oDataA=7, oDataB=FFFFFFFF, oFunct3=000, oFunct7=0, oRegWrite=1.
- ADD x3,x1,x2 with iExMemRd=1 (data AA), iMemWbRd=1 (data BB), iMemWbRd2=2 -> oDataA=AA (EX/MEM priority), oDataB=iMemWbData. Repeat with rs1=x0 and iExMemRd=0 -> oDataA=iRs1Data.
- BEQ with funct3=000/001 -> oFunct7=0100000, oFunct3=000, oBrFunct3 = original, oRegWrite=0. AUIPC with iPc=1000, iImm=2000 -> oDataA=1000, oDataB=2000.
- Hold iReady=0 for 3 cycles while iValid=1 -> oReady=0 and outputs bit-stable. Release -> next instruction is captured on the following edge, none dropped.
- iStall=1 for 1 cycle -> oValid=0 bubble, oReady=0. Simultaneous iFlush=1 and accept -> oValid=0, oRegWrite=0, oMemWrite=0 next cycle.
- Assert iRstN=0 mid-stream with oValid=1 -> next edge: all outputs 0. Release -> first accepted instruction appears after exactly 1 cycle.

Source files
------------

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32I opcode and funct7 constants shared by the ID/EX stage
//
// Purpose: major opcode encodings and the funct7 values the ALU decodes
//          as subtract / arithmetic shift.
// Ports:   none (package).
package rv32_pkg;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;

   localparam logic [6:0] FUNCT7_SUB = 7'b0100000;
   localparam logic [6:0] FUNCT7_SRA = 7'b0100000;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - operand forwarding select for one source register
//
// Purpose: picks EX/MEM data, then MEM/WB data, then register file data
//          for one source register; x0 is never forwarded.
// Ports:   iRs                         source register index
//          iRfData                     register file read data
//          iExMemRegWrite/Rd/Data      younger forwarding source
//          iMemWbRegWrite/Rd/Data      older forwarding source
//          oData                       selected operand
module fwd_mux #(
   parameter int XLEN    = 32,
   parameter int REGADDR = 5
) (
   input  logic [REGADDR-1:0] iRs,
   input  logic [XLEN-1:0]    iRfData,
   input  logic               iExMemRegWrite,
   input  logic [REGADDR-1:0] iExMemRd,
   input  logic [XLEN-1:0]    iExMemData,
   input  logic               iMemWbRegWrite,
   input  logic [REGADDR-1:0] iMemWbRd,
   input  logic [XLEN-1:0]    iMemWbData,
   output logic [XLEN-1:0]    oData
);

   logic rsNonZero;
   assign rsNonZero = (iRs != '0);

   // EX/MEM holds the younger result, so it wins over MEM/WB.
   always_comb begin
      oData = iRfData;
      if (rsNonZero && iExMemRegWrite && (iExMemRd == iRs)) begin
         oData = iExMemData;
      end else if (rsNonZero && iMemWbRegWrite && (iMemWbRd == iRs)) begin
         oData = iMemWbData;
      end
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - registered ID/EX stage feeding the ALU
//
// Purpose: forwards rs1/rs2, selects ALU operands, rewrites funct3/funct7
//          into the ALU operation actually wanted, decodes write/memory
//          controls and registers everything behind a valid/ready handshake
//          with load-use stall and branch flush.
// Ports:   iClk/iRstN            clock, synchronous active-low reset
//          iValid/oReady         upstream handshake
//          iStall/iFlush         bubble insertion / kill
//          iPc..iImm             decoded instruction fields and RF data
//          iExMem*/iMemWb*       forwarding sources
//          iReady/oValid         downstream handshake
//          oDataA..oPc           registered ALU operands and controls
module id_ex_operand_stage #(
   parameter int XLEN    = 32,
   parameter int REGADDR = 5
) (
   input  logic               iClk,
   input  logic               iRstN,
   input  logic               iValid,
   output logic               oReady,
   input  logic               iStall,
   input  logic               iFlush,
   input  logic [XLEN-1:0]    iPc,
   input  logic [6:0]         iOpcode,
   input  logic [2:0]         iFunct3,
   input  logic [6:0]         iFunct7,
   input  logic [REGADDR-1:0] iRs1,
   input  logic [REGADDR-1:0] iRs2,
   input  logic [REGADDR-1:0] iRd,
   input  logic [XLEN-1:0]    iRs1Data,
   input  logic [XLEN-1:0]    iRs2Data,
   input  logic [XLEN-1:0]    iImm,
   input  logic               iExMemRegWrite,
   input  logic [REGADDR-1:0] iExMemRd,
   input  logic [XLEN-1:0]    iExMemData,
   input  logic               iMemWbRegWrite,
   input  logic [REGADDR-1:0] iMemWbRd,
   input  logic [XLEN-1:0]    iMemWbData,
   input  logic               iReady,
   output logic               oValid,
   output logic [XLEN-1:0]    oDataA,
   output logic [XLEN-1:0]    oDataB,
   output logic [2:0]         oFunct3,
   output logic [6:0]         oFunct7,
   output logic [XLEN-1:0]    oStoreData,
   output logic [2:0]         oBrFunct3,
   output logic [REGADDR-1:0] oRd,
   output logic               oRegWrite,
   output logic               oMemRead,
   output logic               oMemWrite,
   output logic [XLEN-1:0]    oPc
);

   import rv32_pkg::*;

   logic [XLEN-1:0] rs1Fwd, rs2Fwd;
   logic [XLEN-1:0] nextA, nextB;
   logic [2:0]      nextF3;
   logic [6:0]      nextF7;
   logic            writesRd, nextMemRead, nextMemWrite, knownOp;
   logic            accept, advance;

   fwd_mux #(.XLEN(XLEN), .REGADDR(REGADDR)) uFwdRs1 (
      .iRs(iRs1), .iRfData(iRs1Data),
      .iExMemRegWrite(iExMemRegWrite), .iExMemRd(iExMemRd), .iExMemData(iExMemData),
      .iMemWbRegWrite(iMemWbRegWrite), .iMemWbRd(iMemWbRd), .iMemWbData(iMemWbData),
      .oData(rs1Fwd)
   );

   fwd_mux #(.XLEN(XLEN), .REGADDR(REGADDR)) uFwdRs2 (
      .iRs(iRs2), .iRfData(iRs2Data),
      .iExMemRegWrite(iExMemRegWrite), .iExMemRd(iExMemRd), .iExMemData(iExMemData),
      .iMemWbRegWrite(iMemWbRegWrite), .iMemWbRd(iMemWbRd), .iMemWbData(iMemWbData),
      .oData(rs2Fwd)
   );

   assign oReady  = iRstN & ~iStall & (~oValid | iReady);
   assign accept  = iValid & oReady;
   assign advance = ~oValid | iReady;

   // Defaults describe an address-add (rs1 + imm); each opcode overrides.
   always_comb begin
      nextA        = rs1Fwd;
      nextB        = iImm;
      nextF3       = 3'b000;
      nextF7       = 7'b0000000;
      writesRd     = 1'b0;
      nextMemRead  = 1'b0;
      nextMemWrite = 1'b0;
      knownOp      = 1'b1;
      case (iOpcode)
         OP: begin
            nextB    = rs2Fwd;
            nextF3   = iFunct3;
            nextF7   = iFunct7;
            writesRd = 1'b1;
         end
         OP_IMM: begin
            nextF3 = iFunct3;
            // Only SRLI/SRAI carry a meaningful funct7 bit; for every other
            // immediate op those bits are immediate and must not become SUB.
            if ((iFunct3 == 3'b101) && iFunct7[5]) nextF7 = FUNCT7_SRA;
            writesRd = 1'b1;
         end
         LOAD: begin
            writesRd    = 1'b1;
            nextMemRead = 1'b1;
         end
         STORE:  nextMemWrite = 1'b1;
         BRANCH: begin
            nextB  = rs2Fwd;
            nextF7 = FUNCT7_SUB;
         end
         LUI: begin
            nextA    = '0;
            writesRd = 1'b1;
         end
         AUIPC: begin
            nextA    = iPc;
            writesRd = 1'b1;
         end
         JAL, JALR: begin
            // ALU computes the link address pc + 4.
            nextA    = iPc;
            nextB    = XLEN'(4);
            writesRd = 1'b1;
         end
         default: knownOp = 1'b0;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         oValid     <= 1'b0;
         oDataA     <= '0;
         oDataB     <= '0;
         oFunct3    <= '0;
         oFunct7    <= '0;
         oStoreData <= '0;
         oBrFunct3  <= '0;
         oRd        <= '0;
         oRegWrite  <= 1'b0;
         oMemRead   <= 1'b0;
         oMemWrite  <= 1'b0;
         oPc        <= '0;
      end else if (iFlush) begin
         oValid    <= 1'b0;
         oRegWrite <= 1'b0;
         oMemRead  <= 1'b0;
         oMemWrite <= 1'b0;
      end else if (accept) begin
         // An unknown opcode lands as a bubble: decode left its controls at 0.
         oValid     <= knownOp;
         oDataA     <= nextA;
         oDataB     <= nextB;
         oFunct3    <= nextF3;
         oFunct7    <= nextF7;
         oStoreData <= rs2Fwd;
         oBrFunct3  <= iFunct3;
         oRd        <= iRd;
         oRegWrite  <= writesRd & (iRd != '0);
         oMemRead   <= nextMemRead;
         oMemWrite  <= nextMemWrite;
         oPc        <= iPc;
      end else if (advance) begin
         // Drain or stall bubble: nothing valid may leave with side effects.
         oValid    <= 1'b0;
         oRegWrite <= 1'b0;
         oMemRead  <= 1'b0;
         oMemWrite <= 1'b0;
      end
   end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

   localparam logic [6:0] OPC_OP    = 7'h33;
   localparam logic [6:0] OPC_IMM   = 7'h13;
   localparam logic [6:0] OPC_LOAD  = 7'h03;
   localparam logic [6:0] OPC_STORE = 7'h23;
   localparam logic [6:0] OPC_BR    = 7'h63;
   localparam logic [6:0] OPC_LUI   = 7'h37;
   localparam logic [6:0] OPC_AUIPC = 7'h17;
   localparam logic [6:0] OPC_JAL   = 7'h6F;
   localparam logic [6:0] OPC_JALR  = 7'h67;

   logic        iClk = 1'b0;
   logic        iRstN, iValid, oReady, iStall, iFlush;
   logic [31:0] iPc, iRs1Data, iRs2Data, iImm, iExMemData, iMemWbData;
   logic [6:0]  iOpcode, iFunct7;
   logic [2:0]  iFunct3;
   logic [4:0]  iRs1, iRs2, iRd, iExMemRd, iMemWbRd;
   logic        iExMemRegWrite, iMemWbRegWrite, iReady, oValid;
   logic [31:0] oDataA, oDataB, oStoreData, oPc;
   logic [2:0]  oFunct3, oBrFunct3;
   logic [6:0]  oFunct7;
   logic [4:0]  oRd;
   logic        oRegWrite, oMemRead, oMemWrite;

   always #5 iClk = ~iClk;

   id_ex_operand_stage #(.XLEN(32), .REGADDR(5)) dut (
      .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady),
      .iStall(iStall), .iFlush(iFlush), .iPc(iPc), .iOpcode(iOpcode),
      .iFunct3(iFunct3), .iFunct7(iFunct7), .iRs1(iRs1), .iRs2(iRs2), .iRd(iRd),
      .iRs1Data(iRs1Data), .iRs2Data(iRs2Data), .iImm(iImm),
      .iExMemRegWrite(iExMemRegWrite), .iExMemRd(iExMemRd), .iExMemData(iExMemData),
      .iMemWbRegWrite(iMemWbRegWrite), .iMemWbRd(iMemWbRd), .iMemWbData(iMemWbData),
      .iReady(iReady), .oValid(oValid), .oDataA(oDataA), .oDataB(oDataB),
      .oFunct3(oFunct3), .oFunct7(oFunct7), .oStoreData(oStoreData),
      .oBrFunct3(oBrFunct3), .oRd(oRd), .oRegWrite(oRegWrite),
      .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oPc(oPc)
   );

   int compared   = 0;
   int mismatched = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] a, b, store, pc;
      logic [2:0]  f3, br;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic        rw, mr, mw, known;
   } exp_t;

   function automatic logic [31:0] fwdVal(input logic [4:0] s, input logic [31:0] rf);
      if (s == 5'd0) return rf;
      if (iExMemRegWrite && iExMemRd == s) return iExMemData;
      if (iMemWbRegWrite && iMemWbRd == s) return iMemWbData;
      return rf;
   endfunction

   function automatic exp_t predict();
      exp_t e;
      logic [31:0] r1, r2;
      r1 = fwdVal(iRs1, iRs1Data);
      r2 = fwdVal(iRs2, iRs2Data);
      e = '0;
      e.pc = iPc; e.rd = iRd; e.br = iFunct3; e.store = r2; e.known = 1'b1;
      e.a = r1; e.b = iImm;
      if (iOpcode == OPC_OP) begin
         e.b = r2; e.f3 = iFunct3; e.f7 = iFunct7; e.rw = 1'b1;
      end else if (iOpcode == OPC_IMM) begin
         e.f3 = iFunct3; e.rw = 1'b1;
         e.f7 = (iFunct3 == 3'd5) ? {1'b0, iFunct7[5], 5'b0} : 7'd0;
      end else if (iOpcode == OPC_LOAD) begin
         e.rw = 1'b1; e.mr = 1'b1;
      end else if (iOpcode == OPC_STORE) begin
         e.mw = 1'b1;
      end else if (iOpcode == OPC_BR) begin
         e.b = r2; e.f7 = 7'h20;
      end else if (iOpcode == OPC_LUI) begin
         e.a = 32'd0; e.rw = 1'b1;
      end else if (iOpcode == OPC_AUIPC) begin
         e.a = iPc; e.rw = 1'b1;
      end else if (iOpcode == OPC_JAL || iOpcode == OPC_JALR) begin
         e.a = iPc; e.b = 32'd4; e.rw = 1'b1;
      end else begin
         e.known = 1'b0;
      end
      if (iRd == 5'd0) e.rw = 1'b0;
      return e;
   endfunction

   exp_t expOut;
   logic expValid = 1'b0;
   logic zeroAll  = 1'b0;
   logic bubble   = 1'b0;
   logic started  = 1'b0;

   function automatic logic modelReady();
      return iRstN && !iStall && (!expValid || iReady);
   endfunction

   always @(posedge iClk) begin
      logic rdy;
      exp_t p;
      rdy = modelReady();
      started = 1'b1;
      if (!iRstN) begin
         expValid = 1'b0; expOut = '0; zeroAll = 1'b1; bubble = 1'b1;
      end else begin
         zeroAll = 1'b0;
         if (iFlush) begin
            expValid = 1'b0; bubble = 1'b1;
         end else if (iValid && rdy) begin
            p = predict();
            if (p.known) begin
               expValid = 1'b1; expOut = p; bubble = 1'b0;
            end else begin
               expValid = 1'b0; bubble = 1'b1;
            end
         end else if (expValid && !iReady) begin
            // downstream holding: expectation unchanged
         end else if (iStall) begin
            expValid = 1'b0; bubble = 1'b1;
         end else begin
            expValid = 1'b0; bubble = 1'b0;
         end
      end
   end

   always @(negedge iClk) begin
      if (started) begin
         chk("m_ready", {31'd0, oReady}, {31'd0, modelReady()});
         chk("m_valid", {31'd0, oValid}, {31'd0, expValid});
         if (zeroAll) begin
            chk("m_rst_dataA", oDataA, 32'd0);
            chk("m_rst_dataB", oDataB, 32'd0);
            chk("m_rst_store", oStoreData, 32'd0);
            chk("m_rst_pc", oPc, 32'd0);
            chk("m_rst_fields", {15'd0, oFunct3, oFunct7, oBrFunct3, oRd, oRegWrite, oMemRead, oMemWrite}, 32'd0);
         end else if (expValid) begin
            chk("m_dataA", oDataA, expOut.a);
            chk("m_dataB", oDataB, expOut.b);
            chk("m_store", oStoreData, expOut.store);
            chk("m_pc", oPc, expOut.pc);
            chk("m_funct3", {29'd0, oFunct3}, {29'd0, expOut.f3});
            chk("m_funct7", {25'd0, oFunct7}, {25'd0, expOut.f7});
            chk("m_brfunct3", {29'd0, oBrFunct3}, {29'd0, expOut.br});
            chk("m_rd", {27'd0, oRd}, {27'd0, expOut.rd});
            chk("m_ctrl", {29'd0, oRegWrite, oMemRead, oMemWrite}, {29'd0, expOut.rw, expOut.mr, expOut.mw});
         end else if (bubble) begin
            chk("m_bubble_ctrl", {29'd0, oRegWrite, oMemRead, oMemWrite}, 32'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic setInstr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [31:0] pc);
      iOpcode = opc; iFunct3 = f3; iFunct7 = f7; iRs1 = rs1; iRs2 = rs2; iRd = rd;
      iRs1Data = d1; iRs2Data = d2; iImm = imm; iPc = pc;
   endtask

   task automatic fwdSet(input logic exW, input logic [4:0] exRd, input logic [31:0] exD,
                         input logic wbW, input logic [4:0] wbRd, input logic [31:0] wbD);
      iExMemRegWrite = exW; iExMemRd = exRd; iExMemData = exD;
      iMemWbRegWrite = wbW; iMemWbRd = wbRd; iMemWbData = wbD;
   endtask

   initial begin
      iRstN = 1'b0; iValid = 1'b0; iStall = 1'b0; iFlush = 1'b0; iReady = 1'b1;
      setInstr(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      fwdSet(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick(); tick();
      chk("rst_ready", {31'd0, oReady}, 32'd0);
      chk("rst_valid", {31'd0, oValid}, 32'd0);

      // ADDI x5,x1,-1 with junk funct7
      iRstN = 1'b1; iValid = 1'b1;
      setInstr(OPC_IMM, 3'b000, 7'b0100000, 5'd1, 5'd0, 5'd5, 32'd7, 32'd0, 32'hFFFFFFFF, 32'h100);
      tick();
      chk("addi_valid", {31'd0, oValid}, 32'd1);
      chk("addi_A", oDataA, 32'd7);
      chk("addi_B", oDataB, 32'hFFFFFFFF);
      chk("addi_f3", {29'd0, oFunct3}, 32'd0);
      chk("addi_f7", {25'd0, oFunct7}, 32'd0);
      chk("addi_rw", {31'd0, oRegWrite}, 32'd1);

      // ADD with both sources hitting rs1: EX/MEM wins
      fwdSet(1'b1, 5'd1, 32'hAA, 1'b1, 5'd1, 32'hBB);
      setInstr(OPC_OP, 3'b000, 7'd0, 5'd1, 5'd1, 5'd3, 32'h11, 32'h22, 32'd0, 32'h104);
      tick();
      chk("fwd_prio_A", oDataA, 32'hAA);
      chk("fwd_prio_B", oDataB, 32'hAA);
      fwdSet(1'b1, 5'd1, 32'hAA, 1'b1, 5'd2, 32'hBB);
      setInstr(OPC_OP, 3'b000, 7'd0, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'd0, 32'h108);
      tick();
      chk("fwd_ex_A", oDataA, 32'hAA);
      chk("fwd_wb_B", oDataB, 32'hBB);
      fwdSet(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
      setInstr(OPC_OP, 3'b000, 7'd0, 5'd0, 5'd2, 5'd3, 32'h1234, 32'h22, 32'd0, 32'h10C);
      tick();
      chk("fwd_x0_A", oDataA, 32'h1234);
      chk("fwd_none_B", oDataB, 32'h22);
      fwdSet(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // SUB passes funct7 through
      setInstr(OPC_OP, 3'b000, 7'h20, 5'd1, 5'd2, 5'd3, 32'd9, 32'd4, 32'd0, 32'h110);
      tick();
      chk("sub_f7", {25'd0, oFunct7}, 32'h20);

      // BEQ / BNE
      setInstr(OPC_BR, 3'b000, 7'd0, 5'd1, 5'd2, 5'd7, 32'd5, 32'd6, 32'd8, 32'h114);
      tick();
      chk("beq_f7", {25'd0, oFunct7}, 32'h20);
      chk("beq_f3", {29'd0, oFunct3}, 32'd0);
      chk("beq_br", {29'd0, oBrFunct3}, 32'd0);
      chk("beq_rw", {31'd0, oRegWrite}, 32'd0);
      setInstr(OPC_BR, 3'b001, 7'd0, 5'd1, 5'd2, 5'd7, 32'd5, 32'd6, 32'd8, 32'h118);
      tick();
      chk("bne_f3", {29'd0, oFunct3}, 32'd0);
      chk("bne_br", {29'd0, oBrFunct3}, 32'd1);
      chk("bne_B", oDataB, 32'd6);

      // AUIPC, JAL, JALR, LUI
      setInstr(OPC_AUIPC, 3'b000, 7'd0, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 32'h2000, 32'h1000);
      tick();
      chk("auipc_A", oDataA, 32'h1000);
      chk("auipc_B", oDataB, 32'h2000);
      setInstr(OPC_JAL, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h40, 32'h2000);
      tick();
      chk("jal_A", oDataA, 32'h2000);
      chk("jal_B", oDataB, 32'd4);
      setInstr(OPC_JALR, 3'b010, 7'd0, 5'd6, 5'd0, 5'd1, 32'h77, 32'd0, 32'h40, 32'h3000);
      tick();
      chk("jalr_A", oDataA, 32'h3000);
      chk("jalr_f3", {29'd0, oFunct3}, 32'd0);
      setInstr(OPC_LUI, 3'b000, 7'd0, 5'd9, 5'd0, 5'd8, 32'h55, 32'd0, 32'h12345000, 32'h3004);
      tick();
      chk("lui_A", oDataA, 32'd0);
      chk("lui_B", oDataB, 32'h12345000);

      // OP-IMM funct7 cleaning
      setInstr(OPC_IMM, 3'b101, 7'h20, 5'd1, 5'd0, 5'd2, 32'd8, 32'd0, 32'h403, 32'h3008);
      tick();
      chk("srai_f7", {25'd0, oFunct7}, 32'h20);
      setInstr(OPC_IMM, 3'b101, 7'h00, 5'd1, 5'd0, 5'd2, 32'd8, 32'd0, 32'h3, 32'h300C);
      tick();
      chk("srli_f7", {25'd0, oFunct7}, 32'h00);
      setInstr(OPC_IMM, 3'b001, 7'h20, 5'd1, 5'd0, 5'd2, 32'd8, 32'd0, 32'h403, 32'h3010);
      tick();
      chk("slli_f7", {25'd0, oFunct7}, 32'h00);
      chk("slli_f3", {29'd0, oFunct3}, 32'd1);

      // LOAD and STORE (store data forwarded from EX/MEM)
      setInstr(OPC_LOAD, 3'b010, 7'd0, 5'd1, 5'd0, 5'd6, 32'h100, 32'd0, 32'h8, 32'h3014);
      tick();
      chk("lw_f3", {29'd0, oFunct3}, 32'd0);
      chk("lw_ctrl", {29'd0, oRegWrite, oMemRead, oMemWrite}, 32'b110);
      fwdSet(1'b1, 5'd3, 32'h77, 1'b0, 5'd0, 32'd0);
      setInstr(OPC_STORE, 3'b010, 7'd0, 5'd1, 5'd3, 5'd4, 32'h100, 32'h55, 32'hC, 32'h3018);
      tick();
      chk("sw_store", oStoreData, 32'h77);
      chk("sw_ctrl", {29'd0, oRegWrite, oMemRead, oMemWrite}, 32'b001);
      fwdSet(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // rd = x0 never writes; unknown opcode becomes a bubble
      setInstr(OPC_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 32'd0, 32'd1, 32'h301C);
      tick();
      chk("x0_rw", {31'd0, oRegWrite}, 32'd0);
      setInstr(7'h7F, 3'b000, 7'd0, 5'd1, 5'd0, 5'd5, 32'd1, 32'd0, 32'd1, 32'h3020);
      tick();
      chk("unk_valid", {31'd0, oValid}, 32'd0);
      chk("unk_rw", {31'd0, oRegWrite}, 32'd0);

      // downstream hold for 3 cycles
      setInstr(OPC_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd9, 32'd1, 32'd0, 32'd2, 32'h4000);
      tick();
      iReady = 1'b0;
      setInstr(OPC_OP, 3'b000, 7'd0, 5'd1, 5'd2, 5'd10, 32'd3, 32'd4, 32'd0, 32'h4004);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_ready", {31'd0, oReady}, 32'd0);
         chk("hold_valid", {31'd0, oValid}, 32'd1);
         chk("hold_A", oDataA, 32'd1);
         chk("hold_B", oDataB, 32'd2);
         chk("hold_rd", {27'd0, oRd}, 32'd9);
      end
      iReady = 1'b1;
      #1;
      chk("release_ready", {31'd0, oReady}, 32'd1);
      tick();
      chk("release_rd", {27'd0, oRd}, 32'd10);
      chk("release_A", oDataA, 32'd3);
      chk("release_B", oDataB, 32'd4);

      // load-use stall for one cycle
      iStall = 1'b1;
      setInstr(OPC_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd11, 32'd5, 32'd0, 32'd6, 32'h4008);
      #1;
      chk("stall_ready", {31'd0, oReady}, 32'd0);
      tick();
      chk("stall_valid", {31'd0, oValid}, 32'd0);
      chk("stall_ctrl", {30'd0, oRegWrite, oMemWrite}, 32'd0);
      iStall = 1'b0;
      tick();
      chk("after_stall_rd", {27'd0, oRd}, 32'd11);
      chk("after_stall_valid", {31'd0, oValid}, 32'd1);

      // flush together with an accept
      iFlush = 1'b1;
      setInstr(OPC_STORE, 3'b010, 7'd0, 5'd1, 5'd2, 5'd0, 32'd5, 32'd6, 32'd4, 32'h400C);
      tick();
      chk("flush_valid", {31'd0, oValid}, 32'd0);
      chk("flush_ctrl", {29'd0, oRegWrite, oMemRead, oMemWrite}, 32'd0);
      iFlush = 1'b0;

      // reset mid-stream
      setInstr(OPC_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd12, 32'd5, 32'd0, 32'd6, 32'h5000);
      tick();
      chk("pre_rst_valid", {31'd0, oValid}, 32'd1);
      iRstN = 1'b0;
      setInstr(OPC_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd14, 32'd5, 32'd0, 32'd6, 32'h5004);
      #1;
      chk("midrst_ready", {31'd0, oReady}, 32'd0);
      tick();
      chk("midrst_valid", {31'd0, oValid}, 32'd0);
      chk("midrst_A", oDataA, 32'd0);
      chk("midrst_pc", oPc, 32'd0);
      chk("midrst_rd", {27'd0, oRd}, 32'd0);
      iRstN = 1'b1;
      setInstr(OPC_LUI, 3'b000, 7'd0, 5'd0, 5'd0, 5'd13, 32'd0, 32'd0, 32'hABCDE000, 32'h5008);
      tick();
      chk("post_rst_valid", {31'd0, oValid}, 32'd1);
      chk("post_rst_rd", {27'd0, oRd}, 32'd13);
      chk("post_rst_B", oDataB, 32'hABCDE000);

      // drain
      iValid = 1'b0;
      tick();
      chk("drain_valid", {31'd0, oValid}, 32'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
